// File: rtl/chameleon_noise_gen.sv
// Renders one 256x256 frame of tinted LFSR noise per enabled vs rising edge, one pixel every PIX_DIV clocks.
// First strobe PIX_DIV cycles after the vs edge; no backpressure, a vs edge arriving mid-frame is dropped and flagged.
module chameleon_noise_gen #(
  parameter int unsigned PIX_DIV   = 4,
  parameter logic [31:0] LFSR_SEED = 32'hACE12345
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       vs,
  input  logic [1:0] noise_sel,
  output logic [7:0] hh,
  output logic [7:0] vv,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       color_ready,
  output logic       frame,
  output logic       busy,
  output logic       dropped
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_RENDER = 2'd1;
  localparam logic [1:0]  ST_FLIP   = 2'd2;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [7:0]  DIV_LAST  = 8'(PIX_DIV - 1);

  logic [1:0]  state;
  logic        vs_d;
  logic [1:0]  sel_q;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [7:0]  div;
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic        vs_rise;
  logic [2:0]  inten;
  logic [2:0]  tint_r;
  logic [2:0]  tint_g;
  logic [1:0]  tint_b;

  assign vs_rise   = vs & ~vs_d;
  assign busy      = (state == ST_RENDER) || (state == ST_FLIP);
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
  assign inten     = lfsr[7:5];

  always_comb begin
    tint_r = 3'd0;
    tint_g = 3'd0;
    tint_b = 2'd0;
    case (sel_q)
      2'd0: begin
        tint_r = inten;
        tint_g = inten;
        tint_b = inten[2:1];
      end
      2'd1:    tint_r = inten;
      2'd2:    tint_g = inten;
      default: tint_b = inten[2:1];
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vs_d    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      vs_d    <= vs;
      dropped <= vs_rise && busy;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      sel_q       <= 2'd0;
      x           <= 8'd0;
      y           <= 8'd0;
      div         <= 8'd0;
      lfsr        <= LFSR_SEED;
      hh          <= 8'd0;
      vv          <= 8'd0;
      red         <= 3'd0;
      green       <= 3'd0;
      blue        <= 2'd0;
      color_ready <= 1'b0;
      frame       <= 1'b0;
    end else begin
      color_ready <= 1'b0;
      frame       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (vs_rise && enable) begin
            sel_q <= noise_sel;
            x     <= 8'd0;
            y     <= 8'd0;
            div   <= 8'd0;
            state <= ST_RENDER;
          end
        end
        ST_RENDER: begin
          // Abort keeps the LFSR where it stopped; the next frame continues the sequence.
          if (!enable) begin
            state <= ST_IDLE;
          end else if (div == DIV_LAST) begin
            color_ready <= 1'b1;
            hh          <= x;
            vv          <= y;
            red         <= tint_r;
            green       <= tint_g;
            blue        <= tint_b;
            lfsr        <= lfsr_next;
            x           <= x + 8'd1;
            div         <= 8'd0;
            if (x == 8'hFF) y <= y + 8'd1;
            if (x == 8'hFF && y == 8'hFF) state <= ST_FLIP;
          end else begin
            div <= div + 8'd1;
          end
        end
        ST_FLIP: begin
          frame <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chameleon_noise_gen.sv
// Bench for chameleon_noise_gen: first-pixel table, randomized abort/overrun runs, one full frame, async reset.
module tb_chameleon_noise_gen;

  localparam int          PD   = 2;
  localparam logic [31:0] SEED = 32'hACE12345;
  localparam int          NPIX = 65536;

  logic       clk_sys   = 1'b0;
  logic       reset_n   = 1'b0;
  logic       enable    = 1'b0;
  logic       vs        = 1'b0;
  logic [1:0] noise_sel = 2'd0;
  logic [7:0] hh;
  logic [7:0] vv;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       color_ready;
  logic       frame;
  logic       busy;
  logic       dropped;

  chameleon_noise_gen #(.PIX_DIV(PD), .LFSR_SEED(SEED)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .vs(vs), .noise_sel(noise_sel),
    .hh(hh), .vv(vv), .red(red), .green(green), .blue(blue),
    .color_ready(color_ready), .frame(frame), .busy(busy), .dropped(dropped)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] px0;
    logic [7:0] px1;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_lfsr = SEED;
  logic [1:0]  m_sel = 2'd0;
  int          pix_idx = 0;
  bit          active = 1'b0;
  int          cyc_cnt = 0;
  int          last_strobe = 0;
  int          strobe_tot = 0;
  int          frame_cnt = 0;
  int          drop_cnt = 0;
  int          frame_cyc = 0;
  logic        frame_busy = 1'b0;
  logic [7:0]  last_hh = 8'd0;
  logic [7:0]  last_vv = 8'd0;
  logic [7:0]  last_rgb = 8'd0;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Packed {red, green, blue} for a given LFSR value and tint.
  function automatic logic [7:0] tint(input logic [31:0] l, input logic [1:0] s);
    logic [2:0] i;
    i = l[7:5];
    case (s)
      2'd0:    return {i, i, i[2:1]};
      2'd1:    return {i, 3'd0, 2'd0};
      2'd2:    return {3'd0, i, 2'd0};
      default: return {3'd0, 3'd0, i[2:1]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock, sample #1 after the edge, score any strobe against the model.
  task automatic cyc();
    logic [23:0] e;
    @(posedge clk_sys);
    #1;
    cyc_cnt++;
    if (color_ready) begin
      chk("strobe_expected", 32'(active && pix_idx < NPIX), 32'd1);
      chk("strobe_gap", cyc_cnt - last_strobe, PD);
      e = {8'(pix_idx % 256), 8'(pix_idx / 256), tint(m_lfsr, m_sel)};
      chk("pixel", 32'({hh, vv, red, green, blue}), 32'(e));
      m_lfsr      = lfsr_step(m_lfsr);
      pix_idx++;
      strobe_tot++;
      last_strobe = cyc_cnt;
      last_hh     = hh;
      last_vv     = vv;
      last_rgb    = {red, green, blue};
    end
    if (frame) begin
      frame_cnt++;
      frame_cyc  = cyc_cnt;
      frame_busy = busy;
    end
    if (dropped) drop_cnt++;
  endtask

  task automatic start_frame();
    vs    = 1'b1;
    m_sel = noise_sel;
    cyc();
    vs          = 1'b0;
    last_strobe = cyc_cnt;
    pix_idx     = 0;
    active      = 1'b1;
  endtask

  task automatic run_until(input int target, input string name);
    int n;
    n = 0;
    while (pix_idx < target && n < (target + 4) * PD + 8) begin
      cyc();
      n++;
    end
    chk(name, 32'(pix_idx >= target), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    vs      = 1'b0;
    active  = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("reset_outputs", 32'({hh, vv, red, green, blue, color_ready, frame, busy, dropped}), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    m_lfsr  = SEED;
    cyc();
    chk("idle_after_reset", 32'({busy, color_ready, frame, dropped}), 32'd0);
  endtask

  initial begin
    vec_t tbl[4];
    int   start, f0, d0, s0, n, npx, ov;
    bit   did;

    tbl[0] = '{2'd0, 8'b010_010_01, 8'b101_101_10};
    tbl[1] = '{2'd1, 8'b010_000_00, 8'b101_000_00};
    tbl[2] = '{2'd2, 8'b000_010_00, 8'b000_101_00};
    tbl[3] = '{2'd3, 8'b000_000_01, 8'b000_000_10};

    // First two pixels from the seed, per tint, with first-strobe latency.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      noise_sel = tbl[t].sel;
      enable    = 1'b1;
      start_frame();
      start = cyc_cnt;
      chk("busy_at_start", 32'(busy), 32'd1);
      run_until(1, "first_strobe_seen");
      chk("first_latency", last_strobe - start, PD);
      chk("first_px", 32'({last_hh, last_vv, last_rgb}), 32'({16'h0000, tbl[t].px0}));
      run_until(2, "second_strobe_seen");
      chk("second_px", 32'({last_hh, last_vv, last_rgb}), 32'({8'd1, 8'd0, tbl[t].px1}));
    end

    // Random partial frames: overrun vs, sel changes mid-frame, then abort; LFSR must carry over.
    do_reset();
    for (int it = 0; it < 6; it++) begin
      noise_sel = 2'($urandom_range(0, 3));
      enable    = 1'b1;
      start_frame();
      npx = $urandom_range(50, 400);
      ov  = $urandom_range(5, npx - 5);
      run_until(ov, "rand_reach_overrun");
      d0 = drop_cnt;
      vs = 1'b1;
      cyc();
      vs = 1'b0;
      chk("rand_dropped", drop_cnt - d0, 1);
      noise_sel = 2'($urandom_range(0, 3));
      run_until(npx, "rand_reach_abort");
      enable = 1'b0;
      s0 = strobe_tot;
      f0 = frame_cnt;
      repeat (3 * PD) cyc();
      chk("abort_strobes_le1", 32'((strobe_tot - s0) <= 1), 32'd1);
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_no_frame", frame_cnt - f0, 0);
      active = 1'b0;
      repeat ($urandom_range(1, 4)) cyc();
    end

    // Full frame with one overrun at pixel 1000.
    enable    = 1'b1;
    noise_sel = 2'($urandom_range(0, 3));
    start_frame();
    f0  = frame_cnt;
    d0  = drop_cnt;
    n   = 0;
    did = 1'b0;
    while (frame_cnt == f0 && n < NPIX * PD + 50) begin
      if (pix_idx == 1000 && !did) begin
        vs = 1'b1;
        cyc();
        vs  = 1'b0;
        did = 1'b1;
      end else begin
        cyc();
      end
      n++;
    end
    chk("frame_seen", frame_cnt - f0, 1);
    chk("frame_strobes", pix_idx, NPIX);
    chk("last_xy", 32'({last_hh, last_vv}), 32'h0000FFFF);
    chk("frame_after_last", frame_cyc - last_strobe, 1);
    chk("busy_at_frame", 32'(frame_busy), 32'd0);
    repeat (4) cyc();
    chk("frame_width", frame_cnt - f0, 1);
    chk("frame_dropped", drop_cnt - d0, 1);
    chk("busy_after_frame", 32'(busy), 32'd0);
    active = 1'b0;

    // Async reset between edges mid-frame, then a clean restart from the seed.
    noise_sel = 2'd0;
    start_frame();
    run_until(10, "areset_reach");
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_outputs", 32'({hh, vv, red, green, blue, color_ready, frame, busy, dropped}), 32'd0);
    active = 1'b0;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    m_lfsr  = SEED;
    f0      = frame_cnt;
    cyc();
    start_frame();
    start = cyc_cnt;
    run_until(1, "areset_first_seen");
    chk("areset_first_latency", last_strobe - start, PD);
    chk("areset_first_px", 32'({last_hh, last_vv, last_rgb}), 32'({16'h0000, 8'b010_010_01}));
    chk("areset_no_frame", frame_cnt - f0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
